// File: rtl/serial_full_adder_pkg.sv
// Shared constants for the bit-serial arithmetic units (adder now, subtractor later).
// Holds the FSM state encodings and the default operand width.
package serial_arith_pkg;

    localparam int SA_WIDTH_DEFAULT = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } sa_state_e;

endpackage

// File: rtl/serial_full_adder_if.sv
// Request/result bundle between a client and serial_full_adder.
// master drives operands and start; slave (the adder) returns the result, busy and done.
interface serial_full_adder_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
);

    logic             inStart;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inCin;
    logic [WIDTH-1:0] outSum;
    logic             outCout;
    logic             outBusy;
    logic             outDone;

    modport master (
        output inStart, inA, inB, inCin,
        input  outSum, outCout, outBusy, outDone
    );

    modport slave (
        input  inStart, inA, inB, inCin,
        output outSum, outCout, outBusy, outDone
    );

endinterface

// File: rtl/serial_full_adder_full_adder.sv
// One-bit full adder cell, purely combinational; mirror of the full_subtractor cell.
// Zero latency, no flow control.
module full_adder (
    input  logic inA,
    input  logic inB,
    input  logic inc,
    output logic outS,
    output logic outc
);

    assign outS = inA ^ inB ^ inc;
    assign outc = (inA & inB) | (inc & (inA ^ inB));

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder reusing one full_adder cell LSB first; result after WIDTH+1 cycles.
// Starts are only taken in IDLE/DONE; a start during RUN is dropped, never queued.
module serial_full_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_full_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sa_state_e        r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_fa (
        .inA  (r_a[0]),
        .inB  (r_b[0]),
        .inc  (r_carry),
        .outS (w_sum),
        .outc (w_cout)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign w_s_next = {w_sum, r_s[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.inStart) begin
                        r_a     <= bus.inA;
                        r_b     <= bus.inB;
                        r_carry <= bus.inCin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_s     <= w_s_next;
                    r_carry <= w_cout;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_cout;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.outSum  = r_sum;
    assign bus.outCout = r_cout;
    assign bus.outBusy = r_busy;
    assign bus.outDone = r_done;

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder (WIDTH=8) against an integer A+B+Cin model.
module tb_serial_full_adder;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    serial_full_adder_if #(.WIDTH(W)) bus ();

    serial_full_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int unsigned s;
        s = int'(a) + int'(b) + int'(c);
        return s[W:0];
    endfunction

    // Called at a negedge: issues a one-cycle start, scrambles inputs during RUN,
    // and returns the negedge index where outDone was first seen (-1 on timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output int busy_cnt);
        bus.inA     = a;
        bus.inB     = b;
        bus.inCin   = c;
        bus.inStart = 1'b1;
        lat         = -1;
        busy_cnt    = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus.inStart = 1'b0;
            bus.inA     = W'($urandom);
            bus.inB     = W'($urandom);
            bus.inCin   = 1'($urandom_range(0, 1));
            if (bus.outBusy) busy_cnt++;
            if (bus.outDone) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int dones;
        rst_n = 1'b0;
        bus.inStart = 1'b0;
        bus.inA = '0;
        bus.inB = '0;
        bus.inCin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.outDone) dones++;
        end
        checks++; if (bus.outSum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", bus.outSum); else passes++;
        checks++; if (bus.outCout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", bus.outCout); else passes++;
        checks++; if (bus.outBusy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.outBusy); else passes++;
        checks++; if (dones !== 0) $display("FAIL reset_done_count got=%0d exp=0", dones); else passes++;
    endtask

    task automatic test_basic();
        int lat, busy;
        logic [W:0] exp;
        logic [W-1:0] a, b;
        logic c;
        run_op(8'h35, 8'h4A, 1'b0, lat, busy);
        checks++; if (lat !== 9) $display("FAIL basic_latency got=%0d exp=9", lat); else passes++;
        checks++; if (busy !== 8) $display("FAIL basic_busy_cycles got=%0d exp=8", busy); else passes++;
        checks++; if (bus.outSum !== 8'h7F) $display("FAIL basic_sum got=%h exp=7f", bus.outSum); else passes++;
        checks++; if (bus.outCout !== 1'b0) $display("FAIL basic_cout got=%b exp=0", bus.outCout); else passes++;
        @(negedge clk);
        checks++; if (bus.outDone !== 1'b0) $display("FAIL basic_done_width got=%b exp=0", bus.outDone); else passes++;
        checks++; if (bus.outSum !== 8'h7F) $display("FAIL basic_sum_hold got=%h exp=7f", bus.outSum); else passes++;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
            exp = model_add(a, b, c);
            run_op(a, b, c, lat, busy);
            checks++;
            if (lat !== 9 || {bus.outCout, bus.outSum} !== exp)
                $display("FAIL random_op a=%h b=%h c=%b got=%b_%h lat=%0d exp=%b_%h lat=9",
                         a, b, c, bus.outCout, bus.outSum, lat, exp[W], exp[W-1:0]);
            else passes++;
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic test_carry();
        int lat, busy;
        run_op(8'hFF, 8'h01, 1'b0, lat, busy);
        checks++; if ({bus.outCout, bus.outSum} !== 9'h100) $display("FAIL carry_ff_01 got=%b_%h exp=1_00", bus.outCout, bus.outSum); else passes++;
        run_op(8'hFF, 8'hFF, 1'b1, lat, busy);
        checks++; if ({bus.outCout, bus.outSum} !== 9'h1FF) $display("FAIL carry_ff_ff_1 got=%b_%h exp=1_ff", bus.outCout, bus.outSum); else passes++;
        checks++; if (lat !== 9) $display("FAIL carry_latency got=%0d exp=9", lat); else passes++;
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [W:0] exp;
        @(negedge clk);
        exp = model_add(8'h12, 8'h34, 1'b0);
        bus.inA = 8'h12; bus.inB = 8'h34; bus.inCin = 1'b0; bus.inStart = 1'b1;
        dones = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            bus.inStart = 1'b0;
            if (n == 3) begin
                bus.inA = 8'h01; bus.inB = 8'h01; bus.inStart = 1'b1;
            end
            if (bus.outDone) begin
                dones++;
                checks++; if ({bus.outCout, bus.outSum} !== exp) $display("FAIL ignore_result got=%b_%h exp=%b_%h", bus.outCout, bus.outSum, exp[W], exp[W-1:0]); else passes++;
            end
        end
        checks++; if (dones !== 1) $display("FAIL ignore_done_count got=%0d exp=1", dones); else passes++;
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int idle;
        bus.inA = 8'h10; bus.inB = 8'h20; bus.inCin = 1'b0; bus.inStart = 1'b1;
        idle = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (!bus.outBusy && !bus.outDone) idle++;
            if (bus.outDone) begin
                done_at.push_back(n);
                checks++; if (bus.outSum !== 8'h30 || bus.outCout !== 1'b0) $display("FAIL b2b_sum got=%b_%h exp=0_30", bus.outCout, bus.outSum); else passes++;
            end
        end
        bus.inStart = 1'b0;
        checks++; if (done_at.size() !== 3) $display("FAIL b2b_done_count got=%0d exp=3", done_at.size()); else passes++;
        checks++; if (idle !== 0) $display("FAIL b2b_idle_cycles got=%0d exp=0", idle); else passes++;
        for (int i = 1; i < done_at.size(); i++) begin
            checks++; if (done_at[i] - done_at[i-1] !== 9) $display("FAIL b2b_interval got=%0d exp=9", done_at[i] - done_at[i-1]); else passes++;
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.outDone) break;
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int dones, lat, busy;
        bus.inA = 8'h55; bus.inB = 8'h66; bus.inCin = 1'b1; bus.inStart = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            bus.inStart = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.outCout, bus.outSum, bus.outBusy, bus.outDone} !== 11'h0) $display("FAIL abort_outputs got=%b_%h_%b_%b exp=0_00_0_0", bus.outCout, bus.outSum, bus.outBusy, bus.outDone); else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.outDone) dones++;
        end
        checks++; if (dones !== 0) $display("FAIL abort_no_done got=%0d exp=0", dones); else passes++;
        checks++; if (bus.outSum !== 8'h00) $display("FAIL abort_sum_after got=%h exp=00", bus.outSum); else passes++;
        run_op(8'h80, 8'h80, 1'b0, lat, busy);
        checks++; if ({bus.outCout, bus.outSum} !== 9'h100) $display("FAIL abort_next_op got=%b_%h exp=1_00", bus.outCout, bus.outSum); else passes++;
        checks++; if (lat !== 9) $display("FAIL abort_next_latency got=%0d exp=9", lat); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
